// File: rtl/serpent_pkg.sv
// rtl/serpent_pkg.sv - shared Serpent types, S-box tables and IP-domain wiring helpers
// Purpose: FSM state type, the eight S-box tables, LT rotation constants and
//          the IP/FP/LT-hat wiring functions. initial_permutation and the
//          final-permutation stage use the same IP/FP functions.
// Ports:   none (package)
package serpent_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int LAST_KEY_IDX = 32;

  localparam int ROT_X0_A = 13;
  localparam int ROT_X2_A = 3;
  localparam int ROT_X1_B = 1;
  localparam int ROT_X3_B = 7;
  localparam int ROT_X0_C = 5;
  localparam int ROT_X2_C = 22;

  localparam logic [3:0] SBOX [8][16] = '{
    '{4'd3, 4'd8, 4'd15,4'd1, 4'd10,4'd6, 4'd5, 4'd11,4'd14,4'd13,4'd4, 4'd2, 4'd7, 4'd0, 4'd9, 4'd12},
    '{4'd15,4'd12,4'd2, 4'd7, 4'd9, 4'd0, 4'd5, 4'd10,4'd1, 4'd11,4'd14,4'd8, 4'd6, 4'd13,4'd3, 4'd4},
    '{4'd8, 4'd6, 4'd7, 4'd9, 4'd3, 4'd12,4'd10,4'd15,4'd13,4'd1, 4'd14,4'd4, 4'd0, 4'd11,4'd5, 4'd2},
    '{4'd0, 4'd15,4'd11,4'd8, 4'd12,4'd9, 4'd6, 4'd3, 4'd13,4'd1, 4'd2, 4'd4, 4'd10,4'd7, 4'd5, 4'd14},
    '{4'd1, 4'd15,4'd8, 4'd3, 4'd12,4'd0, 4'd11,4'd6, 4'd2, 4'd5, 4'd4, 4'd10,4'd9, 4'd14,4'd7, 4'd13},
    '{4'd15,4'd5, 4'd2, 4'd11,4'd4, 4'd10,4'd9, 4'd12,4'd0, 4'd3, 4'd14,4'd8, 4'd13,4'd6, 4'd7, 4'd1},
    '{4'd7, 4'd2, 4'd12,4'd5, 4'd8, 4'd4, 4'd6, 4'd11,4'd14,4'd9, 4'd1, 4'd15,4'd13,4'd3, 4'd10,4'd0},
    '{4'd1, 4'd13,4'd15,4'd0, 4'd14,4'd8, 4'd2, 4'd11,4'd7, 4'd4, 4'd12,4'd10,4'd9, 4'd3, 4'd5, 4'd6}
  };

  function automatic logic [31:0] rol32(input logic [31:0] w, input int n);
    return (w << n) | (w >> (32 - n));
  endfunction

  // IP gathers bit j of each 32-bit word k into nibble j, bit k.
  function automatic logic [127:0] ip_perm(input logic [127:0] x);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 32; j++)
        r[4*j + k] = x[32*k + j];
    return r;
  endfunction

  function automatic logic [127:0] fp_perm(input logic [127:0] x);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 32; j++)
        r[32*k + j] = x[4*j + k];
    return r;
  endfunction

  // Linear transform applied in the IP domain: unpermute, mix words, repermute.
  function automatic logic [127:0] lt_hat(input logic [127:0] y);
    logic [127:0] b;
    logic [31:0]  x0, x1, x2, x3;
    b  = fp_perm(y);
    x0 = b[31:0];
    x1 = b[63:32];
    x2 = b[95:64];
    x3 = b[127:96];
    x0 = rol32(x0, ROT_X0_A);
    x2 = rol32(x2, ROT_X2_A);
    x1 = x1 ^ x0 ^ x2;
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = rol32(x1, ROT_X1_B);
    x3 = rol32(x3, ROT_X3_B);
    x0 = x0 ^ x1 ^ x3;
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = rol32(x0, ROT_X0_C);
    x2 = rol32(x2, ROT_X2_C);
    return ip_perm({x3, x2, x1, x0});
  endfunction

endpackage

// File: rtl/serpent_sbox_layer.sv
// rtl/serpent_sbox_layer.sv - 32 parallel 4-bit Serpent S-box lookups
// Purpose: applies S-box number sel to every nibble of x (nibble n = x[4n+3:4n]).
// Ports:   sel - S-box number 0..7
//          x   - 128-bit IP-domain input
//          y   - 128-bit substituted output
module serpent_sbox_layer
  import serpent_pkg::*;
(
  input  logic [2:0]   sel,
  input  logic [127:0] x,
  output logic [127:0] y
);

  for (genvar n = 0; n < 32; n++) begin : g_nib
    assign y[4*n +: 4] = SBOX[sel][x[4*n +: 4]];
  end

endmodule

// File: rtl/serpent_round_engine.sv
// rtl/serpent_round_engine.sv - iterative one-round-per-clock Serpent encryption core
// Purpose: takes an IP-domain block, runs NUM_ROUNDS rounds plus the final key
//          XOR, and holds the IP-domain result until the FP stage accepts it.
// Ports:   i_clk, i_rst          - clock, synchronous active-high reset
//          i_valid/o_ready/i_data - block input handshake
//          o_key_idx/i_subkey     - subkey read port (combinational RAM read)
//          o_valid/i_ready/o_data - result handshake
//          o_busy                 - high while rounds or the final XOR run
module serpent_round_engine
  import serpent_pkg::*;
#(
  parameter int NUM_ROUNDS = LAST_KEY_IDX
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [127:0] i_data,
  output logic [5:0]   o_key_idx,
  input  logic [127:0] i_subkey,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_data,
  output logic         o_busy
);

  state_t       fsm, fsm_nxt;
  logic [4:0]   rnd, rnd_nxt;
  logic [127:0] state_reg, state_nxt;
  logic [127:0] sbox_in, sbox_out;

  assign sbox_in = state_reg ^ i_subkey;

  serpent_sbox_layer u_sbox (
    .sel (rnd[2:0]),
    .x   (sbox_in),
    .y   (sbox_out)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fsm       <= ST_IDLE;
      rnd       <= '0;
      state_reg <= '0;
    end else begin
      fsm       <= fsm_nxt;
      rnd       <= rnd_nxt;
      state_reg <= state_nxt;
    end
  end

  // Outputs depend on registered state only, so o_key_idx is glitch-free.
  always_comb begin
    fsm_nxt   = fsm;
    rnd_nxt   = rnd;
    state_nxt = state_reg;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    o_busy    = 1'b0;
    o_key_idx = '0;
    o_data    = '0;
    case (fsm)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          state_nxt = i_data;
          rnd_nxt   = '0;
          fsm_nxt   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        o_busy    = 1'b1;
        o_key_idx = {1'b0, rnd};
        // The last round skips the linear transform; the final key XOR follows.
        if (rnd == 5'(NUM_ROUNDS - 1)) begin
          state_nxt = sbox_out;
          fsm_nxt   = ST_FINAL;
        end else begin
          state_nxt = lt_hat(sbox_out);
          rnd_nxt   = rnd + 5'd1;
        end
      end
      ST_FINAL: begin
        o_busy    = 1'b1;
        o_key_idx = 6'(NUM_ROUNDS);
        state_nxt = sbox_in;
        fsm_nxt   = ST_DONE;
      end
      ST_DONE: begin
        o_valid = 1'b1;
        o_data  = state_reg;
        if (i_ready) fsm_nxt = ST_IDLE;
      end
      default: fsm_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serpent_round_engine.sv
// tb/tb_serpent_round_engine.sv - self-checking bench for serpent_round_engine
module tb_serpent_round_engine;

  logic         clk = 1'b0;
  logic         i_rst, i_valid, i_ready;
  logic [127:0] i_data, i_subkey;
  logic         o_ready, o_valid, o_busy;
  logic [5:0]   o_key_idx;
  logic [127:0] o_data;

  logic [127:0] kmem [0:32];
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign i_subkey = (o_key_idx <= 6'd32) ? kmem[o_key_idx] : '0;

  serpent_round_engine #(.NUM_ROUNDS(32)) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
    .o_key_idx (o_key_idx),
    .i_subkey  (i_subkey),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_busy    (o_busy)
  );

  // Reference model works in the bitslice (non-IP) domain.
  int sb [0:7][0:15] = '{
    '{3,8,15,1,10,6,5,11,14,13,4,2,7,0,9,12},
    '{15,12,2,7,9,0,5,10,1,11,14,8,6,13,3,4},
    '{8,6,7,9,3,12,10,15,13,1,14,4,0,11,5,2},
    '{0,15,11,8,12,9,6,3,13,1,2,4,10,7,5,14},
    '{1,15,8,3,12,0,11,6,2,5,4,10,9,14,7,13},
    '{15,5,2,11,4,10,9,12,0,3,14,8,13,6,7,1},
    '{7,2,12,5,8,4,6,11,14,9,1,15,13,3,10,0},
    '{1,13,15,0,14,8,2,11,7,4,12,10,9,3,5,6}
  };

  function automatic logic [31:0] rl(input logic [31:0] w, input int n);
    return (w << n) | (w >> (32 - n));
  endfunction

  function automatic logic [127:0] m_ip(input logic [127:0] x);
    logic [127:0] r = '0;
    for (int k = 0; k < 4; k++) for (int j = 0; j < 32; j++) r[4*j+k] = x[32*k+j];
    return r;
  endfunction

  function automatic logic [127:0] m_fp(input logic [127:0] x);
    logic [127:0] r = '0;
    for (int k = 0; k < 4; k++) for (int j = 0; j < 32; j++) r[32*k+j] = x[4*j+k];
    return r;
  endfunction

  function automatic logic [127:0] m_sbs(input int box, input logic [127:0] x);
    logic [127:0] r = '0;
    logic [3:0]   v;
    for (int j = 0; j < 32; j++) begin
      v = 4'(sb[box][{x[96+j], x[64+j], x[32+j], x[j]}]);
      r[j] = v[0]; r[32+j] = v[1]; r[64+j] = v[2]; r[96+j] = v[3];
    end
    return r;
  endfunction

  function automatic logic [127:0] m_lt(input logic [127:0] b);
    logic [31:0] x0 = b[31:0], x1 = b[63:32], x2 = b[95:64], x3 = b[127:96];
    x0 = rl(x0, 13); x2 = rl(x2, 3);
    x1 = x1 ^ x0 ^ x2; x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = rl(x1, 1); x3 = rl(x3, 7);
    x0 = x0 ^ x1 ^ x3; x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = rl(x0, 5); x2 = rl(x2, 22);
    return {x3, x2, x1, x0};
  endfunction

  function automatic logic [127:0] m_encrypt(input logic [127:0] pt_hat);
    logic [127:0] b = m_fp(pt_hat);
    for (int i = 0; i < 32; i++) begin
      b = m_sbs(i % 8, b ^ m_fp(kmem[i]));
      if (i < 31) b = m_lt(b);
    end
    b = b ^ m_fp(kmem[32]);
    return m_ip(b);
  endfunction

  // Serpent key schedule for a 128-bit key (padded with a single 1 bit), stored as IP-domain subkeys.
  task automatic load_keys(input logic [127:0] key, input logic zero);
    logic [31:0]  w [0:139];
    logic [127:0] k;
    for (int i = 0; i < 140; i++) w[i] = '0;
    w[0] = key[31:0]; w[1] = key[63:32]; w[2] = key[95:64]; w[3] = key[127:96];
    w[4] = 32'd1;
    for (int i = 0; i < 132; i++)
      w[i+8] = rl(w[i] ^ w[i+3] ^ w[i+5] ^ w[i+7] ^ 32'h9e3779b9 ^ 32'(i), 11);
    for (int i = 0; i < 33; i++) begin
      k = {w[4*i+11], w[4*i+10], w[4*i+9], w[4*i+8]};
      kmem[i] = zero ? '0 : m_ip(m_sbs((35 - i) % 8, k));
    end
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Both tasks start and end just after a falling edge.
  task automatic start(input logic [127:0] pt);
    int n = 0;
    while (!o_ready && n < 60) begin @(negedge clk); n++; end
    i_valid = 1'b1;
    i_data  = pt;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!o_valid && n < 60) begin @(negedge clk); n++; end
    chk({nm, "_valid_timeout"}, 128'(o_valid), 128'd1);
  endtask

  typedef struct {
    string        name;
    logic [127:0] pt;
    logic [127:0] key;
    logic         zk;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [5];
  int   vcnt;

  initial begin
    logic [127:0] e_round0;
    vecs[0] = '{"zero_keys",  128'h0, 128'h0, 1'b1, 128'h0};
    vecs[1] = '{"kat_zero",   128'h0, 128'h0, 1'b0, 128'h0};
    vecs[2] = '{"pt_ones",    {4{32'hffffffff}}, 128'h0, 1'b0, 128'h0};
    vecs[3] = '{"pt_pattern", 128'h0123456789abcdeffedcba9876543210,
                128'h000102030405060708090a0b0c0d0e0f, 1'b0, 128'h0};
    vecs[4] = '{"pt_single",  128'h80000000000000000000000000000001,
                128'hdeadbeefcafef00d1122334455667788, 1'b0, 128'h0};
    foreach (vecs[v]) begin
      load_keys(vecs[v].key, vecs[v].zk);
      vecs[v].exp = m_encrypt(vecs[v].pt);
    end
    e_round0 = m_ip(m_lt(m_fp({32{4'h3}})));

    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",   128'(o_ready),   128'd1);
    chk("rst_valid",   128'(o_valid),   128'd0);
    chk("rst_busy",    128'(o_busy),    128'd0);
    chk("rst_data",    o_data,          128'd0);
    chk("rst_key_idx", 128'(o_key_idx), 128'd0);
    i_rst = 1'b0;

    // Latency, key index sequence and single-round state.
    load_keys(128'h0, 1'b1);
    start(128'h0);
    for (int k = 0; k <= 32; k++) begin
      chk($sformatf("lat_key_idx_%0d", k), 128'(o_key_idx), 128'(k));
      chk($sformatf("lat_valid_%0d", k), 128'(o_valid), 128'd0);
      chk($sformatf("lat_busy_%0d", k), 128'(o_busy), 128'd1);
      if (k == 1) chk("round0_state", dut.state_reg, e_round0);
      @(negedge clk);
    end
    chk("lat_valid_at_34", 128'(o_valid), 128'd1);
    chk("lat_data",        o_data, vecs[0].exp);
    chk("done_key_idx",    128'(o_key_idx), 128'd0);
    chk("done_busy",       128'(o_busy), 128'd0);
    @(negedge clk);
    chk("handoff_valid",   128'(o_valid), 128'd0);
    chk("handoff_ready",   128'(o_ready), 128'd1);

    // Table-driven vectors.
    for (int v = 0; v < 5; v++) begin
      load_keys(vecs[v].key, vecs[v].zk);
      start(vecs[v].pt);
      wait_valid(vecs[v].name);
      chk(vecs[v].name, o_data, vecs[v].exp);
      chk({vecs[v].name, "_fp"}, m_fp(o_data), m_fp(vecs[v].exp));
      @(negedge clk);
    end

    // Backpressure.
    load_keys(vecs[3].key, 1'b0);
    i_ready = 1'b0;
    start(vecs[3].pt);
    wait_valid("bp");
    chk("bp_data", o_data, vecs[3].exp);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_data_%0d", c),  o_data, vecs[3].exp);
      chk($sformatf("bp_hold_valid_%0d", c), 128'(o_valid), 128'd1);
      chk($sformatf("bp_hold_ready_%0d", c), 128'(o_ready), 128'd0);
    end
    i_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 128'(o_valid), 128'd0);
    chk("bp_release_ready", 128'(o_ready), 128'd1);

    // Ignored input at T0+5.
    load_keys(vecs[4].key, 1'b0);
    start(vecs[4].pt);
    repeat (3) @(negedge clk);
    i_valid = 1'b1;
    i_data  = vecs[2].pt;
    @(negedge clk);
    i_valid = 1'b0;
    wait_valid("ign");
    chk("ign_data", o_data, vecs[4].exp);
    @(negedge clk);
    vcnt = 0;
    for (int c = 0; c < 45; c++) begin
      if (o_valid) vcnt++;
      @(negedge clk);
    end
    chk("ign_no_second_valid", 128'(vcnt), 128'd0);

    // Reset at T0+17, then a fresh block.
    load_keys(vecs[3].key, 1'b0);
    start(vecs[3].pt);
    repeat (15) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    chk("mrst_ready",   128'(o_ready),   128'd1);
    chk("mrst_valid",   128'(o_valid),   128'd0);
    chk("mrst_data",    o_data,          128'd0);
    chk("mrst_busy",    128'(o_busy),    128'd0);
    chk("mrst_key_idx", 128'(o_key_idx), 128'd0);
    i_rst = 1'b0;
    start(vecs[3].pt);
    wait_valid("mrst_fresh");
    chk("mrst_fresh_data", o_data, vecs[3].exp);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
